control_sequencer: RTL and testbench

- Hardwired control unit for the MiniSRC datapath: the producer of every bus, register and ALU control strobe the datapath consumes.
- Runs the fetch sequence T0-T2, then decodes IR and runs the execute steps for the register-to-register ALU, MUL/DIV, NOP and HALT instructions.
- Sits beside the datapath: IR comes in from it, and one-hot control lines go out to it.

---
 rtl/control_sequencer.sv | 154 +++++++++++++++
 tb/tb_control_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired MiniSRC control unit: fetch T0-T2, then decoded execute steps.
// All strobes are a Moore decode of the sequencer state and the IR fields.
module control_sequencer #(
  parameter int NREGS = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Stop,
  input  logic [31:0]      IR,
  output logic             PCout,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             MDRout,
  output logic             MARin,
  output logic             MDRin,
  output logic             IRin,
  output logic             PCin,
  output logic             Yin,
  output logic             Zin,
  output logic             HIin,
  output logic             LOin,
  output logic             IncPC,
  output logic             Read,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic [3:0]       ALUop,
  output logic             Run
);

  // state | meaning
  // RST   | idle after reset, strobes off
  // T0    | PC -> MAR, PC+1 -> Z
  // T1    | Z -> PC, memory -> MDR
  // T2    | MDR -> IR, decode on exit
  // T3    | first operand -> Y
  // T4    | second operand, ALU -> Z
  // T5    | Zlow -> Ra or LO
  // T6    | Zhigh -> HI (MUL/DIV only)
  // HALT  | stopped until reset
  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu2, is_unary, is_muldiv, is_halt;
  logic [3:0] alu_code;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  always_comb begin
    is_alu2   = 1'b0;
    is_unary  = 1'b0;
    is_muldiv = 1'b0;
    is_halt   = 1'b0;
    alu_code  = 4'h0;
    case (opcode)
      5'b00011: begin is_alu2   = 1'b1; alu_code = 4'h2; end
      5'b00100: begin is_alu2   = 1'b1; alu_code = 4'h3; end
      5'b00101: begin is_alu2   = 1'b1; alu_code = 4'h0; end
      5'b00110: begin is_alu2   = 1'b1; alu_code = 4'h1; end
      5'b00111: begin is_alu2   = 1'b1; alu_code = 4'h7; end
      5'b01000: begin is_alu2   = 1'b1; alu_code = 4'h8; end
      5'b01001: begin is_alu2   = 1'b1; alu_code = 4'h9; end
      5'b01010: begin is_alu2   = 1'b1; alu_code = 4'hA; end
      5'b01011: begin is_alu2   = 1'b1; alu_code = 4'hB; end
      5'b01111: begin is_muldiv = 1'b1; alu_code = 4'h4; end
      5'b10000: begin is_muldiv = 1'b1; alu_code = 4'h6; end
      5'b10001: begin is_unary  = 1'b1; alu_code = 4'hC; end
      5'b10010: begin is_unary  = 1'b1; alu_code = 4'hD; end
      5'b11011: is_halt = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= S_RST;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = S_T2;
      S_T2: begin
        if (is_halt)                             state_d = S_HALT;
        else if (is_alu2 || is_unary || is_muldiv) state_d = S_T3;
        else                                     state_d = Stop ? S_HALT : S_T0;
      end
      S_T3:  state_d = S_T4;
      S_T4:  state_d = S_T5;
      S_T5: begin
        if (is_muldiv) state_d = S_T6;
        else           state_d = Stop ? S_HALT : S_T0;
      end
      S_T6:   state_d = Stop ? S_HALT : S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    PCin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    ALUop    = 4'h0;
    Run      = (state_q != S_RST) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        Rout = NREGS'(1) << (is_muldiv ? ra : rb);
        Yin  = 1'b1;
      end
      // unary ops feed Rb on both operand slots; two-operand ops use Rc
      S_T4: begin
        Rout  = NREGS'(1) << (is_alu2 ? rc : rb);
        ALUop = alu_code;
        Zin   = 1'b1;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) LOin = 1'b1;
        else           Rin  = NREGS'(1) << ra;
      end
      S_T6: begin Zhighout = 1'b1; HIin = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer against a per-instruction step-list model.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Resetn, Stop;
  logic [31:0] IR;
  logic        PCout, Zlowout, Zhighout, MDRout, MARin, MDRin, IRin, PCin;
  logic        Yin, Zin, HIin, LOin, IncPC, Read, Run;
  logic [15:0] Rin, Rout;
  logic [3:0]  ALUop;

  control_sequencer #(.NREGS(16)) dut (
    .Clock(Clock), .Resetn(Resetn), .Stop(Stop), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .PCin(PCin), .Yin(Yin),
    .Zin(Zin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .Rin(Rin), .Rout(Rout), .ALUop(ALUop), .Run(Run)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic run, pcout, zlowout, zhighout, mdrout, marin, mdrin, irin, pcin;
    logic yin, zin, hiin, loin, incpc, read;
    logic [3:0]  aluop;
    logic [15:0] rin, rout;
  } snap_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  snap_t exp_q[$];
  bit    exp_halt;
  snap_t idle;

  task automatic chk(input string tag, input snap_t got, input snap_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic snap_t observe();
    snap_t s;
    s = {Run, PCout, Zlowout, Zhighout, MDRout, MARin, MDRin, IRin, PCin,
         Yin, Zin, HIin, LOin, IncPC, Read, ALUop, Rin, Rout};
    return s;
  endfunction

  function automatic logic [3:0] alu_of(input logic [4:0] op);
    case (op)
      5'd3: return 4'h2;   5'd4: return 4'h3;   5'd5: return 4'h0;
      5'd6: return 4'h1;   5'd7: return 4'h7;   5'd8: return 4'h8;
      5'd9: return 4'h9;   5'd10: return 4'hA;  5'd11: return 4'hB;
      5'd15: return 4'h4;  5'd16: return 4'h6;
      5'd17: return 4'hC;  5'd18: return 4'hD;
      default: return 4'h0;
    endcase
  endfunction

  // Expected strobes for every step from T0 to the last step of the instruction.
  function automatic void build(input logic [31:0] ir);
    logic [4:0] op;
    int ra, rb, rc;
    snap_t s;
    op = ir[31:27]; ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
    exp_q.delete();
    exp_halt = (op == 5'd27);
    s = '0; s.run = 1; s.pcout = 1; s.marin = 1; s.incpc = 1; s.zin = 1; exp_q.push_back(s);
    s = '0; s.run = 1; s.zlowout = 1; s.pcin = 1; s.read = 1; s.mdrin = 1; exp_q.push_back(s);
    s = '0; s.run = 1; s.mdrout = 1; s.irin = 1; exp_q.push_back(s);
    if ((op >= 5'd3 && op <= 5'd11) || op == 5'd17 || op == 5'd18) begin
      s = '0; s.run = 1; s.rout = 16'(1) << rb; s.yin = 1; exp_q.push_back(s);
      s = '0; s.run = 1; s.rout = 16'(1) << ((op >= 5'd17) ? rb : rc);
      s.aluop = alu_of(op); s.zin = 1; exp_q.push_back(s);
      s = '0; s.run = 1; s.zlowout = 1; s.rin = 16'(1) << ra; exp_q.push_back(s);
    end else if (op == 5'd15 || op == 5'd16) begin
      s = '0; s.run = 1; s.rout = 16'(1) << ra; s.yin = 1; exp_q.push_back(s);
      s = '0; s.run = 1; s.rout = 16'(1) << rb; s.aluop = alu_of(op); s.zin = 1;
      exp_q.push_back(s);
      s = '0; s.run = 1; s.zlowout = 1; s.loin = 1; exp_q.push_back(s);
      s = '0; s.run = 1; s.zhighout = 1; s.hiin = 1; exp_q.push_back(s);
    end
  endfunction

  // Entered just after the negedge of the cycle preceding RST exit.
  task automatic do_reset(input string tag);
    Resetn = 1'b0;
    Stop   = 1'b0;
    #1 chk({tag, "_async"}, observe(), idle);
    repeat (2) begin
      @(negedge Clock);
      chk({tag, "_held"}, observe(), idle);
    end
    @(posedge Clock);
    #1 Resetn = 1'b1;
    @(negedge Clock);
    chk({tag, "_rst_state"}, observe(), idle);
  endtask

  // stop_end: Stop value on the final edge; abort_at: step to drop Resetn in (-1 none).
  task automatic run_instr(input logic [31:0] ir, input bit stop_end, input int abort_at);
    build(ir);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge Clock);
      #1;
      if (i == 0) IR = ir;
      Stop = (i == exp_q.size() - 1) ? stop_end : ($urandom_range(0, 3) == 0);
      @(negedge Clock);
      chk($sformatf("op%0d_t%0d", ir[31:27], i), observe(), exp_q[i]);
      if (i == abort_at) begin
        #2 do_reset("abort");
        return;
      end
    end
    if (exp_halt || stop_end) begin
      repeat (10) begin
        @(posedge Clock);
        #1 Stop = $urandom_range(0, 1);
        @(negedge Clock);
        chk("halt_idle", observe(), idle);
      end
      do_reset("halt_exit");
    end
  endtask

  initial begin
    logic [31:0] ir;
    idle   = '0;
    Resetn = 1'b0;
    Stop   = 1'b0;
    IR     = 32'h0;
    repeat (2) begin
      @(negedge Clock);
      chk("reset", observe(), idle);
    end
    @(posedge Clock);
    #1 Resetn = 1'b1;
    @(negedge Clock);
    chk("rst_state", observe(), idle);

    run_instr(32'h2A2B8000, 1'b0, -1);          // AND R4,R5,R7
    run_instr(32'h79300000, 1'b0, -1);          // MUL R2,R6
    run_instr(32'hD0000000, 1'b0, -1);          // NOP
    run_instr(32'h1A2B8000, 1'b0, -1);          // ADD, Stop random mid-instruction
    run_instr(32'h1A2B8000, 1'b1, -1);          // ADD, Stop at end -> HALT
    run_instr(32'h88800000, 1'b0, -1);          // NEG R1,R0
    run_instr(32'h00000000, 1'b0, -1);          // unknown opcode
    run_instr(32'hD0000000, 1'b1, -1);          // NOP then Stop
    run_instr(32'h80000000, 1'b1, -1);          // DIV R0,R0 then Stop
    run_instr(32'hD8000000, 1'b0, -1);          // HALT
    run_instr(32'h22B18000, 1'b0, 4);           // SUB, reset dropped in T4

    for (int n = 0; n < 80; n++) begin
      ir = $urandom;
      case ($urandom_range(0, 5))
        0: ir[31:27] = 5'd15 + 5'($urandom_range(0, 1));
        1: ir[31:27] = 5'd17 + 5'($urandom_range(0, 1));
        2, 3: ir[31:27] = 5'd3 + 5'($urandom_range(0, 8));
        default: ;
      endcase
      run_instr(ir, ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
